// File: rtl/imm_pipe.sv
// imm_pipe -- two-stage, stallable immediate generator for the decode stage.
//
// Takes an instruction word plus an immediate-type code and, two cycles
// later, returns the immediate extended to XLEN. It also returns an error
// flag for unknown types and an unmodified sideband tag.
//
// Optional feature macro: IMM_ERR_CNT_EN
//   When defined, adds a saturating 16-bit count of delivered error beats.
//
// Parameters:
//   XLEN   datapath width, 32 or 64
//   TAG_W  sideband tag width
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  input handshake
//   in_ir           instruction word
//   in_imm_type     immediate type code
//   in_tag          sideband tag, returned with the beat
//   flush           discard every in-flight beat at the next edge
//   out_valid/ready output handshake
//   out_imm         extended immediate
//   out_tag         tag of the output beat
//   out_err         beat carried DEFAULT_TYPE or an unknown code
//   err_count       (IMM_ERR_CNT_EN only) delivered error beats, saturating
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are 1. A producer holding valid=1 keeps its payload
// stable until that edge. in_ready is the only output with a combinational
// path from inputs (out_ready, flush).

module imm_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ir,
  input  logic [2:0]       in_imm_type,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
`ifdef IMM_ERR_CNT_EN
  ,
  output logic [15:0]      err_count
`endif
);

  localparam logic [2:0] I_TYPE       = 3'b000;
  localparam logic [2:0] B_TYPE       = 3'b001;
  localparam logic [2:0] S_TYPE       = 3'b010;
  localparam logic [2:0] U_TYPE       = 3'b011;
  localparam logic [2:0] J_TYPE       = 3'b100;
  localparam logic [2:0] SHAMT_TYPE   = 3'b101;
  localparam logic [2:0] CSR_TYPE     = 3'b110;
  localparam logic [2:0] DEFAULT_TYPE = 3'b111;

  // Stage 1: raw instruction. The opcode bits [6:0] never feed an
  // immediate, so they are not stored.
  logic             s1_valid;
  logic [31:7]      s1_ir;
  logic [2:0]       s1_type;
  logic [TAG_W-1:0] s1_tag;

  // Stage 2: finished immediate.
  logic             s2_valid;
  logic [XLEN-1:0]  s2_imm;
  logic             s2_err;
  logic [TAG_W-1:0] s2_tag;

  logic             s2_load;
  logic             accept;
  logic [XLEN-1:0]  imm_next;
  logic             err_next;
  logic             unused_opcode;

  assign unused_opcode = ^in_ir[6:0];

  // S2 can take a new value when it is empty or its beat leaves this cycle.
  assign s2_load  = !s2_valid || out_ready;
  assign in_ready = !flush && (!s1_valid || s2_load);
  assign accept   = in_valid && in_ready;

  // Valid bits: reset overrides flush, and flush overrides all movement.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid <= s1_valid;
      end
      if (accept) begin
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Data registers carry no reset; a stale payload is masked by its valid bit.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_ir   <= in_ir[31:7];
      s1_type <= in_imm_type;
      s1_tag  <= in_tag;
    end
    if (s2_load && s1_valid) begin
      s2_imm <= imm_next;
      s2_err <= err_next;
      s2_tag <= s1_tag;
    end
  end

  // Immediate extraction. The size casts of $signed operands sign-extend
  // to XLEN. Unsigned operands are zero-extended. For U-type on RV64 this
  // extends from bit 31.
  always_comb begin
    imm_next = '0;
    err_next = 1'b0;
    case (s1_type)
      I_TYPE:     imm_next = XLEN'($signed(s1_ir[31:20]));
      S_TYPE:     imm_next = XLEN'($signed({s1_ir[31:25], s1_ir[11:7]}));
      B_TYPE:     imm_next = XLEN'($signed({s1_ir[31], s1_ir[7], s1_ir[30:25],
                                             s1_ir[11:8], 1'b0}));
      U_TYPE:     imm_next = XLEN'($signed({s1_ir[31:12], 12'b0}));
      J_TYPE:     imm_next = XLEN'($signed({s1_ir[31], s1_ir[19:12], s1_ir[20],
                                             s1_ir[30:21], 1'b0}));
      SHAMT_TYPE: begin
        if (XLEN == 64) imm_next = XLEN'(s1_ir[25:20]);
        else            imm_next = XLEN'(s1_ir[24:20]);
      end
      CSR_TYPE:   imm_next = XLEN'(s1_ir[19:15]);
      DEFAULT_TYPE: begin
        imm_next = '0;
        err_next = 1'b1;
      end
      default: begin
        imm_next = '0;
        err_next = 1'b1;
      end
    endcase
  end

  assign out_valid = s2_valid;
  assign out_imm   = s2_imm;
  assign out_tag   = s2_tag;
  assign out_err   = s2_err;

`ifdef IMM_ERR_CNT_EN
  // Counts only beats that complete the output handshake. A flushed beat
  // never handshakes, so it is never counted.
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 16'h0000;
    end else if (s2_valid && out_ready && s2_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'h0001;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule
